// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmitter and receiver pair: default
// frame geometry, the transmitter state encoding and the frame length.
//
// Configuration macro: UART_TX_PARITY_EN
//   defined   -> an even-parity bit follows the data bits
//   undefined -> frame is start + data + stop
// Both ends of the link must be built with the same setting.
// ---------------------------------------------------------------------------
package uart_pkg;

    localparam int UART_DATA_BITS  = 8;
    localparam int UART_OVERSAMPLE = 8;

`ifdef UART_TX_PARITY_EN
    localparam int UART_FRAME_BITS = UART_DATA_BITS + 3;
`else
    localparam int UART_FRAME_BITS = UART_DATA_BITS + 2;
`endif

    // Oversampling ticks from the start-bit fall to the end of the stop bit.
    localparam int UART_FRAME_TICKS = UART_FRAME_BITS * UART_OVERSAMPLE;

    typedef enum logic [2:0] {
        IDLE,
        ALIGN,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_e;

endpackage

// File: rtl/uart_tx_if.sv
// ---------------------------------------------------------------------------
// uart_tx_if
// Request/status bundle between a byte producer and the UART transmitter.
//   tx_en     producer -> tx   enable for accepting new requests
//   tx_start  producer -> tx   send request, sampled every clk
//   tx_data   producer -> tx   byte to send, captured on acceptance
//   tx        tx -> line       serial output, idles high
//   tx_busy   tx -> producer   frame accepted or in flight
//   tx_done   tx -> producer   one-clk pulse at the end of the stop bit
// master = producer side, slave = transmitter side.
// ---------------------------------------------------------------------------
interface uart_tx_if #(
    parameter int DATA_BITS = uart_pkg::UART_DATA_BITS
);
    logic                 tx_en;
    logic                 tx_start;
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx;
    logic                 tx_busy;
    logic                 tx_done;

    modport master (
        output tx_en, tx_start, tx_data,
        input  tx, tx_busy, tx_done
    );

    modport slave (
        input  tx_en, tx_start, tx_data,
        output tx, tx_busy, tx_done
    );
endinterface

// File: rtl/uart_bit_timer.sv
// ---------------------------------------------------------------------------
// uart_bit_timer
// Counts oversampling ticks within one bit period and flags the last tick.
//   clk      in   system clock
//   rst      in   synchronous reset, active-low
//   tick     in   one-clk oversampling strobe
//   clear    in   hold the counter at zero (between frames / while aligning)
//   bit_end  out  high on the tick that completes a bit period
// The counter wraps to zero on bit_end, which is the launch of the next bit.
// ---------------------------------------------------------------------------
module uart_bit_timer #(
    parameter int OVERSAMPLE = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic clear,
    output logic bit_end
);

    localparam int            CW   = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam logic [CW-1:0] LAST = CW'(OVERSAMPLE - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (tick) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    assign bit_end = tick && !clear && (cnt_q == LAST);

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// ---------------------------------------------------------------------------
// uart_tx
// Serialises a byte as start bit, LSB-first data, optional even parity and
// stop bit. Bit timing is derived from the shared tick_8x strobe so the
// receiver and transmitter run from one baud generator.
//   clk      in   system clock
//   rst      in   synchronous reset, active-low
//   tick_8x  in   one-clk oversampling strobe, OVERSAMPLE per bit
//   bus      slave side of uart_tx_if (tx_en/tx_start/tx_data in,
//            tx/tx_busy/tx_done out)
// Configuration macro: UART_TX_PARITY_EN inserts the PARITY state.
// Requires DATA_BITS >= 2.
// ---------------------------------------------------------------------------
module uart_tx
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = UART_DATA_BITS,
    parameter int OVERSAMPLE = UART_OVERSAMPLE
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    tick_8x,
    uart_tx_if.slave bus
);

    localparam int            BW       = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

    uart_state_e          state_q, state_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
    logic                 tx_q, tx_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
`ifdef UART_TX_PARITY_EN
    logic                 parity_q, parity_d;
`endif
    logic                 bit_end;

    // The tick counter only runs once the start bit is on the line, so the
    // start bit gets a full OVERSAMPLE ticks regardless of acceptance phase.
    uart_bit_timer #(
        .OVERSAMPLE(OVERSAMPLE)
    ) u_bit_timer (
        .clk    (clk),
        .rst    (rst),
        .tick   (tick_8x),
        .clear  ((state_q == IDLE) || (state_q == ALIGN)),
        .bit_end(bit_end)
    );

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        tx_d      = tx_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d  = parity_q;
`endif
        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (bus.tx_start && bus.tx_en) begin
                    shift_d = bus.tx_data;
                    busy_d  = 1'b1;
                    state_d = ALIGN;
`ifdef UART_TX_PARITY_EN
                    parity_d = ^bus.tx_data;
`endif
                end
            end
            ALIGN: begin
                if (tick_8x) begin
                    tx_d    = 1'b0;
                    state_d = START;
                end
            end
            START: begin
                if (bit_end) begin
                    tx_d      = shift_q[0];
                    shift_d   = shift_q >> 1;
                    bit_cnt_d = '0;
                    state_d   = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_cnt_q == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                        tx_d    = parity_q;
                        state_d = PARITY;
`else
                        tx_d    = 1'b1;
                        state_d = STOP;
`endif
                    end else begin
                        // shift_q[0] already holds the next data bit
                        tx_d      = shift_q[0];
                        shift_d   = shift_q >> 1;
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    tx_d    = 1'b1;
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                if (bit_end) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
`ifdef UART_TX_PARITY_EN
            parity_q  <= parity_d;
`endif
        end
    end

    assign bus.tx      = tx_q;
    assign bus.tx_busy = busy_q;
    assign bus.tx_done = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// ---------------------------------------------------------------------------
// tb_uart_tx
// Directed bench for uart_tx: 10 ns clock, one tick_8x every 400 ns.
// Frames are sampled mid-bit and compared against frames built from the
// byte sent; tx_done must arrive exactly UART_FRAME_TICKS ticks after the
// start-bit fall. Honours UART_TX_PARITY_EN in the expected frames.
// ---------------------------------------------------------------------------
module tb_uart_tx;
    import uart_pkg::*;

    logic clk      = 1'b0;
    logic rst      = 1'b0;
    logic tick_8x  = 1'b0;
    bit   tickEnable = 1'b1;

    int checkCount = 0;
    int errorCount = 0;

    uart_tx_if #(.DATA_BITS(UART_DATA_BITS)) bus ();

    uart_tx #(
        .DATA_BITS (UART_DATA_BITS),
        .OVERSAMPLE(UART_OVERSAMPLE)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .tick_8x(tick_8x),
        .bus    (bus.slave)
    );

    // 100 MHz system clock
    always #5 clk = ~clk;

    // One-clk tick every 40 clocks; tickEnable lets a test stall the baud.
    initial begin
        forever begin
            repeat (39) @(negedge clk);
            tick_8x = tickEnable;
            @(negedge clk);
            tick_8x = 1'b0;
        end
    end

    // Hard stop in case something never returns
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Follows one frame from the start-bit fall to tx_done. action selects a
    // disturbance applied mid-frame: 1 = stray request with new data,
    // 2 = drop tx_en, 3 = reset during data bit 3, 4 = stall the ticks.
    task automatic watchFrame(input string tag, input logic [7:0] data, input int action);
        logic [10:0] got;
        logic [10:0] expFrame;
        int          doneTick;
        int          doneSeen;

        got      = '0;
        expFrame = '0;
        expFrame[8:1] = data;
`ifdef UART_TX_PARITY_EN
        expFrame[9]  = ^data;
        expFrame[10] = 1'b1;
`else
        expFrame[9]  = 1'b1;
`endif
        doneTick = 0;

        @(posedge clk iff tick_8x);
        #1;
        checkOutput({tag, "_startFall"}, bus.tx, 1'b0);

        for (int i = 1; i <= UART_FRAME_TICKS + 8; i++) begin
            @(posedge clk iff tick_8x);
            #1;
            if ((i % 8 == 4) && (i / 8 < 11)) got[i / 8] = bus.tx;
            if (bus.tx_done) begin
                doneTick = i;
                break;
            end
            if (i == 20 && action == 1) begin
                bus.tx_start = 1'b1;
                bus.tx_data  = 8'hFF;
                @(posedge clk);
                #1;
                bus.tx_start = 1'b0;
                checkOutput({tag, "_strayBusy"}, bus.tx_busy, 1'b1);
            end
            if (i == 20 && action == 2) bus.tx_en = 1'b0;
            if (i == 20 && action == 4) begin
                tickEnable = 1'b0;
                repeat (200) @(posedge clk);
                #1;
                checkOutput({tag, "_stallTx"}, bus.tx, expFrame[2]);
                checkOutput({tag, "_stallBusy"}, bus.tx_busy, 1'b1);
                tickEnable = 1'b1;
            end
            if (i == 36 && action == 3) begin
                rst = 1'b0;
                @(posedge clk);
                #1;
                checkOutput({tag, "_rstTx"}, bus.tx, 1'b1);
                checkOutput({tag, "_rstBusy"}, bus.tx_busy, 1'b0);
                checkOutput({tag, "_rstDone"}, bus.tx_done, 1'b0);
                rst = 1'b1;
                doneSeen = 0;
                repeat (100) begin
                    @(posedge clk);
                    #1;
                    if (bus.tx_done) doneSeen++;
                end
                checkOutput({tag, "_noDoneAfterRst"}, doneSeen, 0);
                return;
            end
        end

        checkOutput({tag, "_frame"}, got, expFrame);
        checkOutput({tag, "_doneTick"}, doneTick, UART_FRAME_TICKS);
        checkOutput({tag, "_busyFall"}, bus.tx_busy, 1'b0);
        @(posedge clk);
        #1;
        checkOutput({tag, "_donePulse"}, bus.tx_done, 1'b0);
    endtask

    // Requests one frame and follows it; hold leaves tx_start asserted.
    task automatic applyStimulus(input string tag, input logic [7:0] data,
                                 input bit hold, input int action);
        @(negedge clk);
        bus.tx_data  = data;
        bus.tx_start = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) bus.tx_start = 1'b0;
        checkOutput({tag, "_busy"}, bus.tx_busy, 1'b1);
        checkOutput({tag, "_idleHigh"}, bus.tx, 1'b1);
        watchFrame(tag, data, action);
    endtask

    initial begin
        bus.tx_en    = 1'b1;
        bus.tx_start = 1'b0;
        bus.tx_data  = '0;
        rst          = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_tx", bus.tx, 1'b1);
        checkOutput("reset_busy", bus.tx_busy, 1'b0);
        checkOutput("reset_done", bus.tx_done, 1'b0);
        rst = 1'b1;

        // 0x55 with a stray 0xFF request part way through
        applyStimulus("f55", 8'h55, 1'b1 == 1'b0, 1);

        // 0xAA with tx_start held: second frame follows immediately
        applyStimulus("fAA1", 8'hAA, 1'b1, 0);
        checkOutput("b2b_accept", bus.tx_busy, 1'b1);
        bus.tx_start = 1'b0;
        watchFrame("fAA2", 8'hAA, 0);

        // Disabled transmitter ignores requests
        bus.tx_en    = 1'b0;
        bus.tx_data  = 8'h3C;
        bus.tx_start = 1'b1;
        repeat (100) @(posedge clk);
        #1;
        checkOutput("en0_tx", bus.tx, 1'b1);
        checkOutput("en0_busy", bus.tx_busy, 1'b0);
        bus.tx_start = 1'b0;
        bus.tx_en    = 1'b1;

        // Enable dropped mid-frame; frame still completes
        applyStimulus("fC3", 8'hC3, 1'b0, 2);
        bus.tx_en = 1'b1;

        // Reset mid-frame, then a clean resend
        applyStimulus("f18rst", 8'h18, 1'b0, 3);
        applyStimulus("f18", 8'h18, 1'b0, 0);

        // Tick stall holds everything in place
        applyStimulus("f07stall", 8'h07, 1'b0, 4);

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
